// File: rtl/calendar_pkg.sv
// Shared constants, FSM state type and calendar/BCD helper functions for
// the calendar counter.
package calendar_pkg;

  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [4:0] HOUR_MAX  = 5'd23;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} set_state_t;

  // leap_rule: 0 = every fourth year, 1 = Gregorian century exceptions
  function automatic logic is_leap(input logic [13:0] year, input logic leap_rule);
    logic div4;
    logic div100;
    logic div400;
    div4   = (year[1:0] == 2'b00);
    div100 = ((year % 14'd100) == 14'd0);
    div400 = ((year % 14'd400) == 14'd0);
    if (leap_rule) begin
      return div4 && (!div100 || div400);
    end else begin
      return div4;
    end
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                               input logic [13:0] year,
                                               input logic leap_rule);
    logic [4:0] d;
    case (month)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: d = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    d = 5'd30;
      4'd2:    d = is_leap(year, leap_rule) ? 5'd29 : 5'd28;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] bin2bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [15:0] bin2bcd4(input logic [13:0] v);
    return {4'(v / 14'd1000), 4'((v / 14'd100) % 14'd10),
            4'((v / 14'd10) % 14'd10), 4'(v % 14'd10)};
  endfunction

endpackage

// File: rtl/calendar_counter_tick_prescaler.sv
// Divides enabled clk cycles down to a one-per-second advance strobe.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Strobe is qualified by en so a frozen prescaler never advances time
  assign tick = en && (cnt_r == TERM);

  // Counter: clears on reset or a committed set, holds while disabled
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (tick) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/calendar_counter.sv
// Second-resolution calendar counter with validated set handshake,
// binary and BCD outputs and a 12h/24h hour display.
module calendar_counter import calendar_pkg::*; #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int RESET_YEAR = 2024,
  parameter int YEAR_MAX   = 9999,
  parameter int LEAP_RULE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mode_12h,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [5:0]  set_sec,
  input  logic [5:0]  set_min,
  input  logic [4:0]  set_hour,
  input  logic [4:0]  set_day,
  input  logic [3:0]  set_month,
  input  logic [13:0] set_year,
  output logic        set_err,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic [4:0]  hour,
  output logic [4:0]  day,
  output logic [3:0]  month,
  output logic [13:0] year,
  output logic [7:0]  sec_bcd,
  output logic [7:0]  min_bcd,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  day_bcd,
  output logic [7:0]  month_bcd,
  output logic [15:0] year_bcd,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_tick
);

  localparam logic        LEAP_G    = (LEAP_RULE != 0);
  localparam logic [13:0] YEAR_LAST = 14'(YEAR_MAX);
  localparam logic [13:0] YEAR_INIT = 14'(RESET_YEAR);

  set_state_t  state_r;
  logic [5:0]  cap_sec_r, cap_min_r, sec_r, min_r, nxt_sec_s, nxt_min_s;
  logic [4:0]  cap_hour_r, cap_day_r, hour_r, day_r, nxt_hour_s, nxt_day_s, h12_s;
  logic [3:0]  cap_month_r, month_r, nxt_month_s;
  logic [13:0] cap_year_r, year_r, nxt_year_s;
  logic [7:0]  sec_bcd_r, min_bcd_r, hour_bcd_r, day_bcd_r, month_bcd_r;
  logic [15:0] year_bcd_r;
  logic        pm_r, set_ready_r, set_err_r, sec_tick_r, day_tick_r;
  logic        tick_s, legal_s, commit_s, roll_day_s, pm_s;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (commit_s),
    .tick (tick_s)
  );

  assign legal_s = (cap_sec_r <= SEC_MAX) && (cap_min_r <= MIN_MAX) &&
                   (cap_hour_r <= HOUR_MAX) &&
                   (cap_month_r != 4'd0) && (cap_month_r <= MONTH_MAX) &&
                   (cap_day_r != 5'd0) &&
                   (cap_day_r <= days_in_month(cap_month_r, cap_year_r, LEAP_G)) &&
                   (cap_year_r <= YEAR_LAST);
  assign commit_s = (state_r == CHECK) && legal_s;

  // Next time: a committed set wins over a coincident advance
  always_comb begin
    nxt_sec_s   = sec_r;
    nxt_min_s   = min_r;
    nxt_hour_s  = hour_r;
    nxt_day_s   = day_r;
    nxt_month_s = month_r;
    nxt_year_s  = year_r;
    roll_day_s  = 1'b0;
    if (commit_s) begin
      nxt_sec_s   = cap_sec_r;
      nxt_min_s   = cap_min_r;
      nxt_hour_s  = cap_hour_r;
      nxt_day_s   = cap_day_r;
      nxt_month_s = cap_month_r;
      nxt_year_s  = cap_year_r;
    end else if (tick_s) begin
      if (sec_r == SEC_MAX) begin
        nxt_sec_s = 6'd0;
        if (min_r == MIN_MAX) begin
          nxt_min_s = 6'd0;
          if (hour_r == HOUR_MAX) begin
            nxt_hour_s = 5'd0;
            roll_day_s = 1'b1;
            if (day_r == days_in_month(month_r, year_r, LEAP_G)) begin
              nxt_day_s = 5'd1;
              if (month_r == MONTH_MAX) begin
                nxt_month_s = 4'd1;
                nxt_year_s  = (year_r == YEAR_LAST) ? 14'd0 : year_r + 14'd1;
              end else begin
                nxt_month_s = month_r + 4'd1;
              end
            end else begin
              nxt_day_s = day_r + 5'd1;
            end
          end else begin
            nxt_hour_s = hour_r + 5'd1;
          end
        end else begin
          nxt_min_s = min_r + 6'd1;
        end
      end else begin
        nxt_sec_s = sec_r + 6'd1;
      end
    end else begin
      roll_day_s = 1'b0;
    end
  end

  // 12h view of the next hour; midnight and noon both show 12
  always_comb begin
    h12_s = nxt_hour_s;
    pm_s  = 1'b0;
    if (mode_12h) begin
      if (nxt_hour_s == 5'd0) begin
        h12_s = 5'd12;
      end else if (nxt_hour_s > 5'd12) begin
        h12_s = nxt_hour_s - 5'd12;
      end else begin
        h12_s = nxt_hour_s;
      end
      pm_s = (nxt_hour_s >= 5'd12);
    end else begin
      h12_s = nxt_hour_s;
      pm_s  = 1'b0;
    end
  end

  // Time fields, BCD mirrors and tick pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_r       <= 6'd0;
      min_r       <= 6'd0;
      hour_r      <= 5'd0;
      day_r       <= 5'd1;
      month_r     <= 4'd1;
      year_r      <= YEAR_INIT;
      sec_bcd_r   <= 8'h00;
      min_bcd_r   <= 8'h00;
      hour_bcd_r  <= mode_12h ? 8'h12 : 8'h00;
      day_bcd_r   <= 8'h01;
      month_bcd_r <= 8'h01;
      year_bcd_r  <= bin2bcd4(YEAR_INIT);
      pm_r        <= 1'b0;
      sec_tick_r  <= 1'b0;
      day_tick_r  <= 1'b0;
    end else begin
      sec_r       <= nxt_sec_s;
      min_r       <= nxt_min_s;
      hour_r      <= nxt_hour_s;
      day_r       <= nxt_day_s;
      month_r     <= nxt_month_s;
      year_r      <= nxt_year_s;
      sec_bcd_r   <= bin2bcd2({1'b0, nxt_sec_s});
      min_bcd_r   <= bin2bcd2({1'b0, nxt_min_s});
      hour_bcd_r  <= bin2bcd2({2'b00, h12_s});
      day_bcd_r   <= bin2bcd2({2'b00, nxt_day_s});
      month_bcd_r <= bin2bcd2({3'b000, nxt_month_s});
      year_bcd_r  <= bin2bcd4(nxt_year_s);
      pm_r        <= pm_s;
      sec_tick_r  <= tick_s && !commit_s;
      day_tick_r  <= roll_day_s;
    end
  end

  // Set handshake: capture in IDLE, validate and commit/reject in CHECK
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      set_ready_r <= 1'b1;
      set_err_r   <= 1'b0;
      cap_sec_r   <= 6'd0;
      cap_min_r   <= 6'd0;
      cap_hour_r  <= 5'd0;
      cap_day_r   <= 5'd0;
      cap_month_r <= 4'd0;
      cap_year_r  <= 14'd0;
    end else begin
      case (state_r)
        IDLE: begin
          set_err_r <= 1'b0;
          if (set_valid && set_ready_r) begin
            cap_sec_r   <= set_sec;
            cap_min_r   <= set_min;
            cap_hour_r  <= set_hour;
            cap_day_r   <= set_day;
            cap_month_r <= set_month;
            cap_year_r  <= set_year;
            state_r     <= CHECK;
            set_ready_r <= 1'b0;
          end else begin
            state_r     <= IDLE;
            set_ready_r <= 1'b1;
          end
        end
        CHECK: begin
          state_r     <= IDLE;
          set_ready_r <= 1'b1;
          set_err_r   <= !legal_s;
        end
        default: begin
          state_r     <= IDLE;
          set_ready_r <= 1'b1;
          set_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign sec       = sec_r;
  assign min       = min_r;
  assign hour      = hour_r;
  assign day       = day_r;
  assign month     = month_r;
  assign year      = year_r;
  assign sec_bcd   = sec_bcd_r;
  assign min_bcd   = min_bcd_r;
  assign hour_bcd  = hour_bcd_r;
  assign day_bcd   = day_bcd_r;
  assign month_bcd = month_bcd_r;
  assign year_bcd  = year_bcd_r;
  assign pm        = pm_r;
  assign set_ready = set_ready_r;
  assign set_err   = set_err_r;
  assign sec_tick  = sec_tick_r;
  assign day_tick  = day_tick_r;

endmodule

// File: tb/tb_calendar_counter.sv
// Two counters (Gregorian and div-by-4 leap rules) driven in parallel and
// compared each cycle against a seconds-of-day/date reference model.
module tb_calendar_counter;

  localparam int TD = 4;
  localparam int RY = 2024;
  localparam int YM = 9999;

  logic clk = 1'b0;
  logic rst, en, mode_12h, set_valid;
  logic [5:0]  set_sec, set_min;
  logic [4:0]  set_hour, set_day;
  logic [3:0]  set_month;
  logic [13:0] set_year;

  logic        set_ready_o [2];
  logic        set_err_o   [2];
  logic        pm_o        [2];
  logic        sec_tick_o  [2];
  logic        day_tick_o  [2];
  logic [5:0]  sec_o [2];
  logic [5:0]  min_o [2];
  logic [4:0]  hour_o [2];
  logic [4:0]  day_o [2];
  logic [3:0]  month_o [2];
  logic [13:0] year_o [2];
  logic [7:0]  sec_bcd_o [2];
  logic [7:0]  min_bcd_o [2];
  logic [7:0]  hour_bcd_o [2];
  logic [7:0]  day_bcd_o [2];
  logic [7:0]  month_bcd_o [2];
  logic [15:0] year_bcd_o [2];

  always #5 clk = ~clk;

  // Instance 0: Gregorian leap rule; instance 1: divisible-by-4 only
  for (genvar g = 0; g < 2; g++) begin : g_dut
    calendar_counter #(
      .TICK_DIV(TD), .RESET_YEAR(RY), .YEAR_MAX(YM), .LEAP_RULE(g == 0 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h),
      .set_valid(set_valid), .set_ready(set_ready_o[g]),
      .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
      .set_day(set_day), .set_month(set_month), .set_year(set_year),
      .set_err(set_err_o[g]),
      .sec(sec_o[g]), .min(min_o[g]), .hour(hour_o[g]), .day(day_o[g]),
      .month(month_o[g]), .year(year_o[g]),
      .sec_bcd(sec_bcd_o[g]), .min_bcd(min_bcd_o[g]), .hour_bcd(hour_bcd_o[g]),
      .day_bcd(day_bcd_o[g]), .month_bcd(month_bcd_o[g]), .year_bcd(year_bcd_o[g]),
      .pm(pm_o[g]), .sec_tick(sec_tick_o[g]), .day_tick(day_tick_o[g])
    );
  end

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: time of day as seconds since midnight plus a date
  int m_sod [2], m_day [2], m_mon [2], m_yr [2], m_phase [2];
  bit m_check [2], m_ready [2], m_err [2], m_stick [2], m_dtick [2];
  int c_sec [2], c_min [2], c_hour [2], c_day [2], c_mon [2], c_yr [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit leap(int y, int gregorian);
    if (gregorian != 0) return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    return (y % 4 == 0);
  endfunction

  function automatic int dim(int m, int y, int gregorian);
    int t [13];
    t = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (m == 2 && leap(y, gregorian)) return 29;
    return t[m];
  endfunction

  function automatic int to_bcd(int v);
    int r = 0;
    for (int k = 0; k < 4; k++) begin
      r = r | ((v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit legal, commit, tick;
      m_stick[i] = 0;
      m_dtick[i] = 0;
      if (rst) begin
        m_sod[i] = 0; m_day[i] = 1; m_mon[i] = 1; m_yr[i] = RY; m_phase[i] = 0;
        m_check[i] = 0; m_ready[i] = 1; m_err[i] = 0;
      end else begin
        legal = (c_sec[i] < 60) && (c_min[i] < 60) && (c_hour[i] < 24) &&
                (c_day[i] >= 1) && (c_day[i] <= dim(c_mon[i], c_yr[i], i == 0)) &&
                (c_yr[i] <= YM);
        commit = m_check[i] && legal;
        m_err[i] = m_check[i] && !legal;
        tick = en && (m_phase[i] == TD - 1);
        if (commit) begin
          m_sod[i] = c_hour[i] * 3600 + c_min[i] * 60 + c_sec[i];
          m_day[i] = c_day[i]; m_mon[i] = c_mon[i]; m_yr[i] = c_yr[i];
          m_phase[i] = 0;
        end else begin
          if (en) m_phase[i] = (m_phase[i] + 1) % TD;
          if (tick) begin
            m_stick[i] = 1;
            m_sod[i]++;
            if (m_sod[i] == 86400) begin
              m_sod[i] = 0;
              m_dtick[i] = 1;
              m_day[i]++;
              if (m_day[i] > dim(m_mon[i], m_yr[i], i == 0)) begin
                m_day[i] = 1;
                m_mon[i]++;
                if (m_mon[i] > 12) begin
                  m_mon[i] = 1;
                  m_yr[i] = (m_yr[i] == YM) ? 0 : m_yr[i] + 1;
                end
              end
            end
          end
        end
        if (m_check[i]) begin
          m_check[i] = 0;
          m_ready[i] = 1;
        end else if (set_valid && m_ready[i]) begin
          c_sec[i] = set_sec; c_min[i] = set_min; c_hour[i] = set_hour;
          c_day[i] = set_day; c_mon[i] = set_month; c_yr[i] = set_year;
          m_check[i] = 1;
          m_ready[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int h, mi, s, hd;
      bit pmx;
      h = m_sod[i] / 3600;
      mi = (m_sod[i] / 60) % 60;
      s = m_sod[i] % 60;
      if (mode_12h) begin
        hd = (h % 12 == 0) ? 12 : h % 12;
        pmx = (h >= 12);
      end else begin
        hd = h;
        pmx = 0;
      end
      check($sformatf("bin%0d", i),
            {sec_o[i], min_o[i], hour_o[i], day_o[i], month_o[i], year_o[i]},
            {6'(s), 6'(mi), 5'(h), 5'(m_day[i]), 4'(m_mon[i]), 14'(m_yr[i])});
      check($sformatf("bcd%0d", i),
            {sec_bcd_o[i], min_bcd_o[i], hour_bcd_o[i], day_bcd_o[i], month_bcd_o[i], year_bcd_o[i]},
            {8'(to_bcd(s)), 8'(to_bcd(mi)), 8'(to_bcd(hd)), 8'(to_bcd(m_day[i])),
             8'(to_bcd(m_mon[i])), 16'(to_bcd(m_yr[i]))});
      check($sformatf("flags%0d", i),
            {set_ready_o[i], set_err_o[i], pm_o[i], sec_tick_o[i], day_tick_o[i]},
            {m_ready[i], m_err[i], pmx, m_stick[i], m_dtick[i]});
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_set(int s, int mi, int h, int d, int mo, int y);
    int guard = 0;
    while (!set_ready_o[0] && guard < 5) begin
      step();
      guard++;
    end
    check("set_ready_wait", set_ready_o[0], 1);
    set_sec = 6'(s); set_min = 6'(mi); set_hour = 5'(h);
    set_day = 5'(d); set_month = 4'(mo); set_year = 14'(y);
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    step();
  endtask

  task automatic advance_one();
    repeat (TD) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: no finish within time budget");
    $fatal(1);
  end

  initial begin
    int saved_sec;
    int guard;
    rst = 1'b1; en = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
    set_sec = 6'd0; set_min = 6'd0; set_hour = 5'd0;
    set_day = 5'd0; set_month = 4'd0; set_year = 14'd0;
    step();
    step();
    check("rst_time", {sec_o[0], min_o[0], hour_o[0], day_o[0], month_o[0], year_o[0]},
          {6'd0, 6'd0, 5'd0, 5'd1, 4'd1, 14'd2024});
    check("rst_year_bcd", year_bcd_o[0], 16'h2024);
    check("rst_flags", {set_ready_o[0], set_err_o[0], sec_tick_o[0], day_tick_o[0], pm_o[0]}, 5'b10000);

    rst = 1'b0; en = 1'b1;
    repeat (3) step();
    check("tick_early", sec_tick_o[0], 1'b0);
    step();
    check("tick_first", {sec_tick_o[0], sec_o[0]}, {1'b1, 6'd1});

    do_set(59, 59, 23, 28, 2, 2024);
    advance_one();
    check("leap2024_g", {hour_o[0], day_o[0], month_o[0], day_tick_o[0]}, {5'd0, 5'd29, 4'd2, 1'b1});
    check("leap2024_j", {day_o[1], month_o[1]}, {5'd29, 4'd2});
    do_set(59, 59, 23, 28, 2, 2100);
    advance_one();
    check("y2100_greg", {day_o[0], month_o[0]}, {5'd1, 4'd3});
    check("y2100_div4", {day_o[1], month_o[1]}, {5'd29, 4'd2});
    do_set(59, 59, 23, 31, 12, 9999);
    advance_one();
    check("year_wrap", {sec_o[0], min_o[0], hour_o[0], day_o[0], month_o[0], year_o[0]},
          {6'd0, 6'd0, 5'd0, 5'd1, 4'd1, 14'd0});
    check("year_wrap_bcd", year_bcd_o[0], 16'h0000);
    do_set(59, 59, 23, 30, 4, 2024);
    advance_one();
    check("apr30", {day_o[0], month_o[0]}, {5'd1, 4'd5});

    do_set(0, 0, 10, 31, 4, 2024);
    check("err_apr31", set_err_o[0], 1'b1);
    step();
    check("err_pulse_end", set_err_o[0], 1'b0);
    do_set(0, 0, 24, 1, 1, 2024);
    check("err_hour24", set_err_o[0], 1'b1);

    guard = 0;
    while (m_phase[0] != TD - 2 && guard < 2 * TD) begin
      step();
      guard++;
    end
    do_set(10, 20, 5, 15, 6, 2030);
    check("set_at_tc", {sec_tick_o[0], sec_o[0], min_o[0], hour_o[0]}, {1'b0, 6'd10, 6'd20, 5'd5});

    mode_12h = 1'b1;
    do_set(0, 0, 0, 1, 1, 2024);
    check("h12_midnight", {hour_bcd_o[0], pm_o[0]}, {8'h12, 1'b0});
    do_set(0, 0, 12, 1, 1, 2024);
    check("h12_noon", {hour_bcd_o[0], pm_o[0]}, {8'h12, 1'b1});
    do_set(0, 0, 15, 1, 1, 2024);
    check("h12_15", {hour_bcd_o[0], pm_o[0]}, {8'h03, 1'b1});
    mode_12h = 1'b0;
    step();
    check("h24_15", {hour_bcd_o[0], pm_o[0]}, {8'h15, 1'b0});

    en = 1'b0;
    saved_sec = m_sod[0] % 60;
    repeat (10) step();
    check("en_frozen", sec_o[0], 6'(saved_sec));
    en = 1'b1;

    set_sec = 6'd0; set_min = 6'd0; set_hour = 5'd24;
    set_day = 5'd1; set_month = 4'd1; set_year = 14'd2024;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    rst = 1'b1;
    step();
    check("rst_in_check", {set_err_o[0], set_ready_o[0], sec_o[0], hour_o[0], year_o[0]},
          {1'b0, 1'b1, 6'd0, 5'd0, 14'd2024});
    rst = 1'b0;

    for (int n = 0; n < 2000; n++) begin
      int ysel;
      rst = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0) mode_12h = ~mode_12h;
      if (!set_valid && $urandom_range(0, 15) == 0) begin
        set_valid = 1'b1;
        set_sec = 6'($urandom_range(56, 60));
        set_min = 6'($urandom_range(58, 60));
        set_hour = 5'($urandom_range(22, 24));
        set_day = 5'($urandom_range(27, 32));
        set_month = 4'($urandom_range(0, 13));
        ysel = $urandom_range(0, 6);
        case (ysel)
          0: set_year = 14'd2024;
          1: set_year = 14'd2100;
          2: set_year = 14'd2000;
          3: set_year = 14'd1900;
          4: set_year = 14'd9999;
          5: set_year = 14'd10000;
          default: set_year = 14'($urandom_range(0, 16383));
        endcase
      end
      step();
      if (set_valid && (m_check[0] || rst)) set_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
